cic_interp_stage: RTL
=====================

// Module: cic_interp_stage
// PURPOSE
//  Downstream of the 2x IFIR second stage: N-stage CIC interpolator, raises the IFIR output rate by R.
//  Zero-stuffs at clock rate and smooths with comb/integrator chain; unity DC gain after fixed shift.
//  Feeds the sigma-delta modulator. Single clock domain: one output sample per clock_in cycle.
// PARAMETERS
//  DW     24  input/output sample width (signed two's complement)
//  R       8  interpolation ratio, power of 2
//  LOG2R   3  log2(R)
//  N       3  number of comb and integrator stages
//  W  (local) DW+N*LOG2R = 33, internal datapath width
//  S  (local) (N-1)*LOG2R = 6, output right-shift to cancel gain R^(N-1)
// PORTS
//  clock_in  in   1   clock at output rate (R x input sample rate); all logic on rising edge
//  rst       in   1   synchronous, active-high reset
//  Data_in   in   DW  input sample from IFIR second stage, signed
//  in_valid  in   1   one-cycle strobe, Data_in valid; nominally every R cycles
//  Data_out  out  DW  interpolated sample, signed, new value every cycle once out_valid=1
//  out_valid out  1   output stream valid
//  rate_err  out  1   sticky: in_valid spacing violated
//  sat_flag  out  1   sticky: output saturation occurred
// BEHAVIOUR
//  Reset (rst=1 at edge): combs, integrators, counter, Data_out, out_valid, rate_err, sat_flag, primed all 0.
//  Comb chain: updates only on in_valid cycles; c0=sext(Data_in); ck=c(k-1)-dly_k; dly_k<=c(k-1).
//   Comb output register cN_q <= cN on in_valid, else 0 (zero-stuffing).
//  Integrators: every cycle, i1<=i1+cN_q, ik<=ik+i(k-1)_q; modulo-2^W wrap is intended, no saturation.
//  Output reg: y=iN>>>S with round-half-up (add 1<<(S-1) before shift), saturate to DW signed;
//   clip sets sat_flag.
//  Latency: in_valid at edge t -> first affected Data_out at edge t+N+2 (5 with defaults).
//  out_valid: 0 until edge t0+N+2 after first post-reset in_valid (t0); then 1 every cycle until rst.
//  Rate check: cnt (LOG2R bits) <=0 on in_valid, else cnt+1 mod R; primed<=1 on first in_valid.
//   - in_valid with primed=1 and cnt!=R-1 (early): sample accepted, cnt<=0, rate_err<=1.
//   - no in_valid with primed=1 and cnt==R-1 (missing): comb not clocked, zero injected, cnt wraps, rate_err<=1.
//   - first in_valid after reset never sets rate_err.
//  rate_err, sat_flag clear only by rst.
//  rst mid-stream: all state cleared on that edge; next in_valid restarts priming; no stale output.
//  DC: constant input x gives steady-state Data_out == x exactly (gain R^N/R/2^S = 1).
// STRUCTURE
//  Shared package dac_cic_pkg: DW, default R/N/LOG2R, function cic_width(DW,N,LOG2R), round/sat function.
//  One sub-module: cic_integrator (W-bit registered accumulator with sync reset), instantiated N times
//   via generate; combs and rate checker stay inline.
// TESTING
//  Impulse: one in_valid with Data_in=0x001000, then zeros on-rate -> 22 outputs 64*h[n],
//   h=1,3,6,10,15,21,28,36,42,46,48,48,46,42,36,28,21,15,10,6,3,1; first at t+5; then 0.
//  Step: Data_in=0x100000 every 8 cycles -> Data_out monotone rise, settles 0x100000 within 3R cycles;
//   flags stay 0.
//  Full scale: constant 0x7FFFFF, then 0x800000 -> outputs reach exactly 0x7FFFFF / 0x800000,
//   no wrap; sat_flag stays 0.
//  Alternating 0x7FFFFF/0x800000 every input -> outputs bounded, any clip pins 0x7FFFFF/0x800000,
//   sat_flag=1.
//  Timing faults: in_valid at spacing 5 -> rate_err=1 next cycle; spacing 9 -> rate_err=1 at missing slot;
//   stream continues.
//  rst=1 mid-impulse response -> next edge Data_out=0, out_valid=0, flags=0; new impulse reproduces
//   test 1 exactly.

Source files
------------

// File: rtl/dac_cic_pkg.sv
// Shared constants and arithmetic helpers for the DAC CIC interpolator.
package dac_cic_pkg;

    localparam int DW    = 24;
    localparam int R     = 8;
    localparam int LOG2R = 3;
    localparam int N     = 3;

    // Internal width: input width plus one bit of growth per log2(R) per stage.
    function automatic int cic_width(input int dw, input int n, input int log2r);
        return dw + n * log2r;
    endfunction

    localparam int W = cic_width(DW, N, LOG2R);
    // Output shift cancels the R^(N-1) passband gain of the zero-stuffed chain.
    localparam int S = (N - 1) * LOG2R;

    localparam logic [W:0]    RND_HALF = {{(W + 1 - S){1'b0}}, 1'b1, {(S - 1){1'b0}}};
    localparam logic [DW-1:0] SAT_MAX  = {1'b0, {(DW - 1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN  = {1'b1, {(DW - 1){1'b0}}};

    typedef struct packed {
        logic [DW-1:0] y;
        logic          clip;
    } rnd_sat_t;

    // Round half-up, arithmetic shift by S, then clip to the DW-bit signed range.
    function automatic rnd_sat_t round_sat(input logic [W-1:0] acc);
        logic [W:0]   sum_s;
        logic [W-S:0] shr_s;
        rnd_sat_t     res_s;
        sum_s = {acc[W-1], acc} + RND_HALF;
        shr_s = sum_s[W:S];
        if ((&shr_s[W-S:DW-1]) || !(|shr_s[W-S:DW-1])) begin
            res_s.y    = shr_s[DW-1:0];
            res_s.clip = 1'b0;
        end else begin
            res_s.y    = shr_s[W-S] ? SAT_MIN : SAT_MAX;
            res_s.clip = 1'b1;
        end
        return res_s;
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// One CIC integrator: W-bit registered accumulator; wrap-around is part of the
// CIC arithmetic and cancels against the comb differences.
module cic_integrator
    import dac_cic_pkg::*;
(
    input  logic         clock_in,
    input  logic         rst,
    input  logic [W-1:0] acc_in,
    output logic [W-1:0] acc_out
);

    logic [W-1:0] acc_r;

    // Accumulate the upstream value every clock; cleared by synchronous reset.
    always_ff @(posedge clock_in) begin
        if (rst) begin
            acc_r <= {W{1'b0}};
        end else begin
            acc_r <= acc_r + acc_in;
        end
    end

    assign acc_out = acc_r;

endmodule

// File: rtl/cic_interp_stage.sv
// N-stage CIC interpolator by R: combs at input rate, zero-stuffing, integrators
// at clock rate, rounded/saturated output, input-rate watchdog and sticky flags.
module cic_interp_stage
    import dac_cic_pkg::*;
(
    input  logic          clock_in,
    input  logic          rst,
    input  logic [DW-1:0] Data_in,
    input  logic          in_valid,
    output logic [DW-1:0] Data_out,
    output logic          out_valid,
    output logic          rate_err,
    output logic          sat_flag
);

    localparam logic [LOG2R-1:0] CNT_LAST = LOG2R'(R - 1);
    localparam logic [LOG2R-1:0] CNT_ONE  = {{(LOG2R - 1){1'b0}}, 1'b1};

    logic [DW-1:0]    din_r;
    logic             vld_r;
    logic [W-1:0]     dly_r [N];
    logic [W-1:0]     tap_s [N];
    logic [W-1:0]     comb_out_s;
    logic [W-1:0]     comb_q_r;
    logic [W-1:0]     integ_s [N+1];
    rnd_sat_t         rs_s;
    logic [DW-1:0]    data_out_r;
    logic             sat_flag_r;
    logic [LOG2R-1:0] cnt_r;
    logic             primed_r;
    logic             rate_err_r;
    logic [N:0]       vsh_r;
    logic             out_valid_r;

    // Input capture stage in front of the comb chain.
    always_ff @(posedge clock_in) begin
        if (rst) begin
            din_r <= {DW{1'b0}};
            vld_r <= 1'b0;
        end else begin
            din_r <= Data_in;
            vld_r <= in_valid;
        end
    end

    // Comb chain: each stage subtracts the value its input had on the previous sample.
    always_comb begin
        logic [W-1:0] run_s;
        run_s = {{(W - DW){din_r[DW-1]}}, din_r};
        for (int k = 0; k < N; k++) begin
            tap_s[k] = run_s;
            run_s    = run_s - dly_r[k];
        end
        comb_out_s = run_s;
    end

    // Comb delays advance only on accepted samples; the output register zero-stuffs.
    always_ff @(posedge clock_in) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                dly_r[k] <= {W{1'b0}};
            end
            comb_q_r <= {W{1'b0}};
        end else if (vld_r) begin
            for (int k = 0; k < N; k++) begin
                dly_r[k] <= tap_s[k];
            end
            comb_q_r <= comb_out_s;
        end else begin
            comb_q_r <= {W{1'b0}};
        end
    end

    assign integ_s[0] = comb_q_r;

    for (genvar g = 0; g < N; g++) begin : g_integ
        cic_integrator u_integ (
            .clock_in (clock_in),
            .rst      (rst),
            .acc_in   (integ_s[g]),
            .acc_out  (integ_s[g+1])
        );
    end

    // Scale the last integrator back to unity gain.
    always_comb begin
        rs_s = round_sat(integ_s[N]);
    end

    // Registered output sample and sticky saturation flag.
    always_ff @(posedge clock_in) begin
        if (rst) begin
            data_out_r <= {DW{1'b0}};
            sat_flag_r <= 1'b0;
        end else begin
            data_out_r <= rs_s.y;
            sat_flag_r <= sat_flag_r | rs_s.clip;
        end
    end

    // Input spacing watchdog: flags early samples and missing slots once primed.
    always_ff @(posedge clock_in) begin
        if (rst) begin
            cnt_r      <= {LOG2R{1'b0}};
            primed_r   <= 1'b0;
            rate_err_r <= 1'b0;
        end else if (in_valid) begin
            cnt_r    <= {LOG2R{1'b0}};
            primed_r <= 1'b1;
            if (primed_r && (cnt_r != CNT_LAST)) begin
                rate_err_r <= 1'b1;
            end
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
            if (primed_r && (cnt_r == CNT_LAST)) begin
                rate_err_r <= 1'b1;
            end
        end
    end

    // out_valid follows the first accepted sample through the pipeline depth.
    always_ff @(posedge clock_in) begin
        if (rst) begin
            vsh_r       <= {(N + 1){1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            vsh_r       <= {vsh_r[N-1:0], primed_r};
            out_valid_r <= vsh_r[N];
        end
    end

    assign Data_out  = data_out_r;
    assign sat_flag  = sat_flag_r;
    assign rate_err  = rate_err_r;
    assign out_valid = out_valid_r;

endmodule
